pipeline_stall_controller: RTL
==============================

Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage pipeline.
- Merges the load-use stall request from hazard detection, the EX-stage control redirect, the data-memory wait handshake and HLT decode into per-stage register enables and flushes.
- Owns halt draining, memory-timeout error and saturating stall/flush performance counters.
- Sits beside the hazard detection unit; drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- DRAIN_CYCLES, 3: cycles after HLT leaves ID before the core is declared halted (EX, MEM, WB retire).
- MEM_TIMEOUT, 64: maximum consecutive MEM_WAIT cycles before error halt.
- CNT_W, 16: width of performance counters.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_req  in  1  load-use stall request from hazard detection unit
- ex_redirect  in  1  branch taken / jump resolved in EX this cycle
- halt_id  in  1  HLT opcode valid in ID
- dmem_req  in  1  MEM stage holds a LW/SW access
- dmem_ready  in  1  data memory completes access this cycle
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID register enable
- id_ex_en  out  1  ID/EX register enable
- ex_mem_en  out  1  EX/MEM register enable
- mem_wb_en  out  1  MEM/WB register enable
- if_id_flush  out  1  clear IF/ID to NOP (synchronous with enable)
- id_ex_flush  out  1  clear ID/EX to NOP
- halted  out  1  core stopped
- mem_err  out  1  sticky memory timeout flag
- stall_cnt  out  CNT_W  saturating count of stall or freeze cycles
- flush_cnt  out  CNT_W  saturating count of redirect flushes

Behaviour:
- Reset (async, rst_n=0): state=RUN, drain_cnt=0, wait_cnt=0, draining=0, halted=0, mem_err=0, both counters=0. With idle inputs all enables=1, flushes=0.
- Enables/flushes: combinational from state and inputs (act the same cycle). State, counters and flags: registered.
- States: RUN, MEM_WAIT, DRAIN, HALTED. Per-cycle priority within RUN/DRAIN: memory freeze > redirect > load-use stall > halt.
- Memory freeze (dmem_req=1, dmem_ready=0): all five enables=0, flushes=0, stall_cnt+1. Next state MEM_WAIT, wait_cnt=1.
- MEM_WAIT:
  - Outputs frozen as above while dmem_ready=0; wait_cnt increments each cycle.
  - When dmem_ready=1: evaluate the RUN rules that cycle (pipeline advances) and return to RUN, or to DRAIN if draining=1.
  - When wait_cnt reaches MEM_TIMEOUT with dmem_ready=0: go to HALTED, set mem_err=1.
- Redirect (ex_redirect=1, no freeze): pc_en=1, if_id_flush=1, id_ex_flush=1, all enables=1, flush_cnt+1.
  - Overrides stall_req and halt_id, because those younger instructions are squashed.
  - In DRAIN, redirect is ignored: HLT is older than nothing in flight.
- Load-use stall (stall_req=1, no freeze, no redirect): pc_en=0, if_id_en=0, id_ex_flush=1 (bubble), downstream enables=1, stall_cnt+1.
- Halt (halt_id=1, none of the above): pc_en=0, if_id_flush=1, others=1. Set draining=1, drain_cnt=1, next state DRAIN.
- DRAIN:
  - pc_en=0, if_id_en=0, id_ex_flush=1, downstream enables=1.
  - drain_cnt increments; on reaching DRAIN_CYCLES go to HALTED.
  - A memory freeze during DRAIN takes priority: go to MEM_WAIT with draining preserved, drain_cnt held.
- HALTED: all enables=0, flushes=0, halted=1. Counters stop. Exit only via rst_n.
- Counters: saturate at all-ones, never wrap.
- Reset mid-freeze or mid-drain returns to the reset values immediately, independent of clk.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (2-bit: RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3);
  - the CNT_W default;
  - a packed struct for the enable/flush bundle.
- One sub-module: sat_counter (width parameter; inc, clk, rst_n; saturating), instantiated for stall_cnt and flush_cnt.

Test Plan:
- Reset then idle inputs for 5 cycles -> all enables=1, flushes=0, halted=0, counters=0.
- stall_req=1 for 1 cycle -> that cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1 next cycle; with stall_req=0 outputs return to all enables=1.
- stall_req=1 and ex_redirect=1 together -> pc_en=1, if_id_flush=1, id_ex_flush=1; flush_cnt=1, stall_cnt=0.
- dmem_req=1 with dmem_ready=0 for 4 cycles, then dmem_ready=1 -> enables=0 for 4 cycles, all=1 on the 5th; stall_cnt=4; state returns to RUN.
- halt_id=1 pulse -> DRAIN for 3 cycles, then halted=1 and all enables=0. A later ex_redirect=1 has no effect; rst_n low clears halted asynchronously.
- dmem_req=1 with dmem_ready held 0 (MEM_TIMEOUT=8) -> mem_err=1 and halted=1 after 8 wait cycles; both remain set until reset.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall controller: sequencer states and the
// per-stage enable/flush bundle driven into the pipeline registers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  // Bundle literals, listed PC-first: five enables then the two flushes.
  localparam ctrl_t CTRL_ADVANCE  = ctrl_t'(7'b11111_00);
  localparam ctrl_t CTRL_FREEZE   = ctrl_t'(7'b00000_00);
  localparam ctrl_t CTRL_REDIRECT = ctrl_t'(7'b11111_11);
  localparam ctrl_t CTRL_BUBBLE   = ctrl_t'(7'b00111_01);
  localparam ctrl_t CTRL_HALT_ID  = ctrl_t'(7'b01111_10);

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters;
// it sticks at all-ones instead of wrapping.
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central pipeline sequencer: turns memory waits, EX redirects, load-use stalls
// and HLT into per-stage enables/flushes, and owns halt draining and timeouts.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req,
  input  logic             ex_redirect,
  input  logic             halt_id,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WaitW  = $clog2(MEM_TIMEOUT + 1);
  localparam int DrainW = $clog2(DRAIN_CYCLES + 2);

  state_e            state_q, state_d;
  state_e            mode;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              draining_q, draining_d;
  logic              mem_err_q, mem_err_d;
  logic              freeze;
  logic              stall_inc;
  logic              flush_inc;
  ctrl_t             ctl;

  assign freeze = dmem_req && !dmem_ready;

  // A completed memory access lets MEM_WAIT behave like the state it interrupted.
  always_comb begin
    mode = state_q;
    if ((state_q == MEM_WAIT) && dmem_ready) begin
      mode = draining_q ? DRAIN : RUN;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    drain_d    = drain_q;
    draining_d = draining_q;
    mem_err_d  = mem_err_q;
    ctl        = CTRL_ADVANCE;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    case (mode)
      RUN, DRAIN: begin
        if (freeze) begin
          ctl       = CTRL_FREEZE;
          stall_inc = 1'b1;
          state_d   = MEM_WAIT;
          wait_d    = WaitW'(1);
        end else if (mode == DRAIN) begin
          ctl     = CTRL_BUBBLE;
          wait_d  = '0;
          drain_d = drain_q + DrainW'(1);
          state_d = (drain_q >= DrainW'(DRAIN_CYCLES)) ? HALTED : DRAIN;
        end else begin
          wait_d  = '0;
          state_d = RUN;
          if (ex_redirect) begin
            ctl       = CTRL_REDIRECT;
            flush_inc = 1'b1;
          end else if (stall_req) begin
            ctl       = CTRL_BUBBLE;
            stall_inc = 1'b1;
          end else if (halt_id) begin
            ctl        = CTRL_HALT_ID;
            draining_d = 1'b1;
            drain_d    = DrainW'(1);
            state_d    = DRAIN;
          end
        end
      end
      MEM_WAIT: begin
        ctl       = CTRL_FREEZE;
        stall_inc = 1'b1;
        wait_d    = wait_q + WaitW'(1);
        if (wait_d >= WaitW'(MEM_TIMEOUT)) begin
          state_d   = HALTED;
          mem_err_d = 1'b1;
        end
      end
      HALTED: begin
        ctl = CTRL_FREEZE;
      end
      default: begin
        ctl = CTRL_FREEZE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_q     <= '0;
      drain_q    <= '0;
      draining_q <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      drain_q    <= drain_d;
      draining_q <= draining_d;
      mem_err_q  <= mem_err_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign pc_en       = ctl.pc_en;
  assign if_id_en    = ctl.if_id_en;
  assign id_ex_en    = ctl.id_ex_en;
  assign ex_mem_en   = ctl.ex_mem_en;
  assign mem_wb_en   = ctl.mem_wb_en;
  assign if_id_flush = ctl.if_id_flush;
  assign id_ex_flush = ctl.id_ex_flush;
  assign halted      = (state_q == HALTED);
  assign mem_err     = mem_err_q;

endmodule
